conv_arbiter: RTL and testbench



---
 rtl/conv_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_conv_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_arbiter: round-robin sharing of one binary-to-BCD converter among   |
// | f0 / f1 / time-difference requesters. Optional macro: ARB_HOLD_EN.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module conv_arbiter #(
  parameter int TIMEOUT = 2048,
  parameter int BW      = 32,
  parameter int DW      = 40
) (
  input  logic          clk_100M,
  input  logic          rst,
`ifdef ARB_HOLD_EN
  input  logic          hold,
`endif
  input  logic          req_f0,
  input  logic [27:0]   freq_0,
  input  logic          req_f1,
  input  logic [27:0]   freq_1,
  input  logic          req_d,
  input  logic [31:0]   differ,
  output logic          cv_start,
  output logic [BW-1:0] cv_bin,
  input  logic          cv_done,
  input  logic [DW-1:0] cv_bcd,
  output logic [DW-1:0] bcd_f0,
  output logic [DW-1:0] bcd_f1,
  output logic [DW-1:0] bcd_d,
  output logic [2:0]    upd,
  output logic          err,
  output logic          busy
);

  localparam int c_CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_STORE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2:0]           r_pend;
  logic [BW-1:0]        r_hold_f0;
  logic [BW-1:0]        r_hold_f1;
  logic [BW-1:0]        r_hold_d;
  logic [1:0]           r_ptr;
  logic [1:0]           r_grant;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_inc;
  logic [BW-1:0]        r_cv_bin;
  logic [DW-1:0]        r_bcd_f0;
  logic [DW-1:0]        r_bcd_f1;
  logic [DW-1:0]        r_bcd_d;
  logic [2:0]           r_upd;
  logic                 r_err;

  logic                 w_hold;
  logic [2:0]           w_req;
  logic [2:0]           w_clr;
  logic [1:0]           w_gidx;
  logic [BW-1:0]        w_gval;
  logic                 w_grant;
  logic                 w_take;
  logic                 w_timeout;

`ifdef ARB_HOLD_EN
  assign w_hold = hold;
`else
  assign w_hold = 1'b0;
`endif

  assign w_req     = {req_d, req_f1, req_f0};
  assign w_cnt_inc = r_cnt + c_CNT_W'(1);

  // Round-robin pick: first pending bit at or above the pointer, wrapping mod 3
  always_comb begin
    w_gidx = 2'd0;
    case (r_ptr)
      2'd1: begin
        if (r_pend[1])      w_gidx = 2'd1;
        else if (r_pend[2]) w_gidx = 2'd2;
        else                w_gidx = 2'd0;
      end
      2'd2: begin
        if (r_pend[2])      w_gidx = 2'd2;
        else if (r_pend[0]) w_gidx = 2'd0;
        else                w_gidx = 2'd1;
      end
      default: begin
        if (r_pend[0])      w_gidx = 2'd0;
        else if (r_pend[1]) w_gidx = 2'd1;
        else                w_gidx = 2'd2;
      end
    endcase
  end

  always_comb begin
    w_gval = r_hold_f0;
    case (w_gidx)
      2'd1:    w_gval = r_hold_f1;
      2'd2:    w_gval = r_hold_d;
      default: w_gval = r_hold_f0;
    endcase
  end

  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_take      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((|r_pend) && !w_hold) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        // A done arriving in the expiry cycle still completes the conversion
        if (cv_done) begin
          w_take      = 1'b1;
          w_state_nxt = ST_STORE;
        end else if (w_cnt_inc == c_TMO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_STORE: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_clr = w_grant ? (3'b001 << w_gidx) : 3'b000;

  // New strobe beats the grant clear so a value arriving mid-grant stays queued
  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      r_pend    <= 3'b000;
      r_hold_f0 <= '0;
      r_hold_f1 <= '0;
      r_hold_d  <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_req;
      if (req_f0) r_hold_f0 <= BW'(freq_0);
      if (req_f1) r_hold_f1 <= BW'(freq_1);
      if (req_d)  r_hold_d  <= BW'(differ);
    end
  end

  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      r_cv_bin <= '0;
      r_grant  <= 2'd0;
      r_ptr    <= 2'd0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_grant) begin
        r_cv_bin <= w_gval;
        r_grant  <= w_gidx;
      end
      if (r_state == ST_LOAD)      r_cnt <= '0;
      else if (r_state == ST_WAIT) r_cnt <= w_cnt_inc;
      if (w_timeout) r_err <= 1'b1;
      if (r_state == ST_STORE) r_ptr <= (r_grant == 2'd2) ? 2'd0 : r_grant + 2'd1;
    end
  end

  // Result lands on the done edge so bcd/upd appear during the STORE cycle
  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      r_bcd_f0 <= '0;
      r_bcd_f1 <= '0;
      r_bcd_d  <= '0;
      r_upd    <= 3'b000;
    end else begin
      r_upd <= 3'b000;
      if (w_take) begin
        r_upd <= 3'b001 << r_grant;
        case (r_grant)
          2'd1:    r_bcd_f1 <= cv_bcd;
          2'd2:    r_bcd_d  <= cv_bcd;
          default: r_bcd_f0 <= cv_bcd;
        endcase
      end
    end
  end

  assign cv_start = (r_state == ST_LOAD);
  assign busy     = (r_state != ST_IDLE);
  assign cv_bin   = r_cv_bin;
  assign bcd_f0   = r_bcd_f0;
  assign bcd_f1   = r_bcd_f1;
  assign bcd_d    = r_bcd_d;
  assign upd      = r_upd;
  assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_conv_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_conv_arbiter: directed bench for conv_arbiter (ARB_HOLD_EN optional). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_conv_arbiter;

  localparam int TIMEOUT = 2048;
  localparam int BW      = 32;
  localparam int DW      = 40;

  logic          clk_100M = 1'b0;
  logic          rst;
  logic          hold;
  logic          req_f0, req_f1, req_d;
  logic [27:0]   freq_0, freq_1;
  logic [31:0]   differ;
  logic          cv_start;
  logic [BW-1:0] cv_bin;
  logic          cv_done;
  logic [DW-1:0] cv_bcd;
  logic [DW-1:0] bcd_f0, bcd_f1, bcd_d;
  logic [2:0]    upd;
  logic          err;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clk_100M = ~clk_100M;

  conv_arbiter #(.TIMEOUT(TIMEOUT), .BW(BW), .DW(DW)) dut (
    .clk_100M (clk_100M),
    .rst      (rst),
`ifdef ARB_HOLD_EN
    .hold     (hold),
`endif
    .req_f0   (req_f0),
    .freq_0   (freq_0),
    .req_f1   (req_f1),
    .freq_1   (freq_1),
    .req_d    (req_d),
    .differ   (differ),
    .cv_start (cv_start),
    .cv_bin   (cv_bin),
    .cv_done  (cv_done),
    .cv_bcd   (cv_bcd),
    .bcd_f0   (bcd_f0),
    .bcd_f1   (bcd_f1),
    .bcd_d    (bcd_d),
    .upd      (upd),
    .err      (err),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100M);
    #1;
  endtask

  task automatic wait_start(input int n, input string tag);
    int i;
    i = 0;
    while (cv_start !== 1'b1 && i < n) begin
      tick();
      i++;
    end
    check(tag, {63'd0, cv_start}, 64'd1);
  endtask

  // From the cv_start cycle: done after lat cycles; returns in the STORE cycle
  task automatic respond(input int lat, input logic [DW-1:0] val);
    repeat (lat) tick();
    cv_done = 1'b1;
    cv_bcd  = val;
    tick();
    cv_done = 1'b0;
    cv_bcd  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic no_start(input int n, input string tag);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      tick();
      seen = seen | cv_start;
    end
    check(tag, {63'd0, seen}, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] upd_seen;
    rst = 1'b0; hold = 1'b0;
    req_f0 = 1'b0; req_f1 = 1'b0; req_d = 1'b0;
    freq_0 = '0; freq_1 = '0; differ = '0;
    cv_done = 1'b0; cv_bcd = '0;
    repeat (3) tick();
    check("rst cv_start", {63'd0, cv_start}, 64'd0);
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst cv_bin", {32'd0, cv_bin}, 64'd0);
    check("rst bcd_f0", {24'd0, bcd_f0}, 64'd0);
    check("rst upd/err", {60'd0, upd, err}, 64'd0);
    rst = 1'b1;

    // Single f0 conversion with latency checks
    req_f0 = 1'b1; freq_0 = 28'd1234567;
    tick();
    req_f0 = 1'b0;
    check("t1 c1 idle", {62'd0, cv_start, busy}, 64'd0);
    tick();
    check("t1 c2 start", {62'd0, cv_start, busy}, 64'd3);
    check("t1 cv_bin", {32'd0, cv_bin}, 64'd1234567);
    respond(35, 40'h0001234567);
    check("t1 bcd_f0", {24'd0, bcd_f0}, 64'h0001234567);
    check("t1 upd", {61'd0, upd}, 64'd1);
    tick();
    check("t1 upd pulse end", {61'd0, upd}, 64'd0);
    check("t1 idle again", {63'd0, busy}, 64'd0);

    // Simultaneous requests from reset pointer
    do_reset();
    req_f0 = 1'b1; req_f1 = 1'b1; req_d = 1'b1;
    freq_0 = 28'd11; freq_1 = 28'd22; differ = 32'd33;
    tick();
    req_f0 = 1'b0; req_f1 = 1'b0; req_d = 1'b0;
    wait_start(10, "t2 start f0");
    check("t2 bin f0", {32'd0, cv_bin}, 64'd11);
    respond(3, 40'h11);
    check("t2 upd f0", {61'd0, upd}, 64'd1);
    check("t2 bcd_f0", {24'd0, bcd_f0}, 64'h11);
    wait_start(10, "t2 start f1");
    check("t2 bin f1", {32'd0, cv_bin}, 64'd22);
    respond(3, 40'h22);
    check("t2 upd f1", {61'd0, upd}, 64'd2);
    check("t2 bcd_f1", {24'd0, bcd_f1}, 64'h22);
    wait_start(10, "t2 start d");
    check("t2 bin d", {32'd0, cv_bin}, 64'd33);
    respond(3, 40'h33);
    check("t2 upd d", {61'd0, upd}, 64'd4);
    check("t2 bcd_d", {24'd0, bcd_d}, 64'h33);

    // Coalescing of f1 strobes while d converts
    req_d = 1'b1; differ = 32'd77;
    tick();
    req_d = 1'b0;
    wait_start(10, "t3 start d");
    tick();
    req_f1 = 1'b1; freq_1 = 28'd10;
    tick();
    freq_1 = 28'd20;
    tick();
    freq_1 = 28'd30;
    tick();
    req_f1 = 1'b0;
    respond(2, 40'h77);
    check("t3 upd d", {61'd0, upd}, 64'd4);
    wait_start(10, "t3 start f1");
    check("t3 bin f1", {32'd0, cv_bin}, 64'd30);
    respond(2, 40'h30);
    check("t3 upd f1", {61'd0, upd}, 64'd2);
    check("t3 bcd_f1", {24'd0, bcd_f1}, 64'h30);
    no_start(10, "t3 single f1");

    // Timeout with a request queued behind it
    req_f0 = 1'b1; freq_0 = 28'd5;
    tick();
    req_f0 = 1'b0;
    wait_start(10, "t4 start f0");
    upd_seen = 3'b000;
    for (int i = 1; i <= TIMEOUT - 1; i++) begin
      tick();
      if (i == 1) begin req_f1 = 1'b1; freq_1 = 28'd6; end
      if (i == 2) req_f1 = 1'b0;
      upd_seen = upd_seen | upd;
    end
    check("t4 err before expiry", {63'd0, err}, 64'd0);
    check("t4 no upd in wait", {61'd0, upd_seen}, 64'd0);
    tick();
    check("t4 err at expiry", {63'd0, err}, 64'd1);
    check("t4 idle after abort", {60'd0, upd, busy}, 64'd0);
    check("t4 bcd_f0 kept", {24'd0, bcd_f0}, 64'h11);
    wait_start(10, "t4 start f1");
    check("t4 bin f1", {32'd0, cv_bin}, 64'd6);
    respond(4, 40'h6);
    check("t4 upd f1", {61'd0, upd}, 64'd2);
    check("t4 err sticky", {63'd0, err}, 64'd1);

    // Reset during WAIT, then a stray done
    req_d = 1'b1; differ = 32'd99;
    tick();
    req_d = 1'b0;
    wait_start(10, "t5 start d");
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("t5 async state", {61'd0, cv_start, busy, err}, 64'd0);
    check("t5 async cv_bin", {32'd0, cv_bin}, 64'd0);
    check("t5 async bcd", {24'd0, bcd_f0 | bcd_f1 | bcd_d}, 64'd0);
    tick();
    rst = 1'b1;
    cv_done = 1'b1; cv_bcd = 40'hdead;
    tick();
    cv_done = 1'b0; cv_bcd = '0;
    check("t5 stray done", {60'd0, upd, busy}, 64'd0);
    check("t5 bcd_d zero", {24'd0, bcd_d}, 64'd0);
    no_start(5, "t5 nothing pending");

    // Strobe in the grant cycle stays pending
    req_f0 = 1'b1; freq_0 = 28'd100;
    tick();
    freq_0 = 28'd200;
    tick();
    req_f0 = 1'b0;
    check("t7 start", {63'd0, cv_start}, 64'd1);
    check("t7 bin old", {32'd0, cv_bin}, 64'd100);
    respond(1, 40'h100);
    check("t7 bcd_f0 old", {24'd0, bcd_f0}, 64'h100);
    wait_start(10, "t7 start new");
    check("t7 bin new", {32'd0, cv_bin}, 64'd200);
    respond(1, 40'h200);
    check("t7 bcd_f0 new", {24'd0, bcd_f0}, 64'h200);

    // Done in the expiry cycle wins over timeout
    req_f1 = 1'b1; freq_1 = 28'd77;
    tick();
    req_f1 = 1'b0;
    wait_start(10, "t6 start f1");
    respond(TIMEOUT - 1, 40'h77);
    check("t6 err clear", {63'd0, err}, 64'd0);
    check("t6 upd f1", {61'd0, upd}, 64'd2);
    check("t6 bcd_f1", {24'd0, bcd_f1}, 64'h77);

`ifdef ARB_HOLD_EN
    tick();
    hold = 1'b1;
    req_d = 1'b1; differ = 32'd500;
    tick();
    differ = 32'd900;
    tick();
    req_d = 1'b0;
    no_start(10, "t8 held");
    hold = 1'b0;
    wait_start(10, "t8 start d");
    check("t8 bin d", {32'd0, cv_bin}, 64'd900);
    respond(2, 40'h900);
    check("t8 upd d", {61'd0, upd}, 64'd4);
    no_start(10, "t8 single d");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
